// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32 core types.
// M-extension divide opcodes and divider FSM states.
package rv32_pkg;

  localparam int XLEN  = 32;
  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } md_div_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring shift-subtract step.
// rem_in/quo_in -> shifted, conditionally reduced rem_out/quo_out.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN:0]   rem_in,
  input  logic [XLEN-1:0] quo_in,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN:0]   rem_out,
  output logic [XLEN-1:0] quo_out
);

  logic [XLEN:0]   sh;
  logic [XLEN+1:0] diff;
  logic            borrow;
  logic            unused_msb;

  // rem stays below the divisor, so its top bit is always 0
  assign unused_msb = rem_in[XLEN];

  assign sh      = {rem_in[XLEN-1:0], quo_in[XLEN-1]};
  assign diff    = {1'b0, sh} - {2'b00, divisor};
  assign borrow  = diff[XLEN+1];
  assign rem_out = borrow ? sh : diff[XLEN:0];
  assign quo_out = {quo_in[XLEN-2:0], ~borrow};

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU for the EX stage.
// start/flush/op/dividend/divisor in; busy, done pulse, result out.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);
  import rv32_pkg::*;

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  div_state_e      state;
  md_div_op_e      op_q;
  logic [CW-1:0]   cnt;
  logic [XLEN:0]   rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] dvs_q;
  logic [XLEN-1:0] res_fin;
  logic [XLEN-1:0] res_q;
  logic            negq_q;
  logic            negr_q;
  logic            done_q;
  logic            busy_q;

  logic            sa;
  logic            sb;
  logic [XLEN-1:0] abs_a;
  logic [XLEN-1:0] abs_b;
  logic            dz;
  logic            ovf;
  logic [XLEN-1:0] spec_val;
  logic [XLEN:0]   rem_nx;
  logic [XLEN-1:0] quo_nx;
  logic [XLEN-1:0] q_fix;
  logic [XLEN-1:0] r_fix;
  logic            is_rem;

  assign sa    = ~op[0] & dividend[XLEN-1];
  assign sb    = ~op[0] & divisor[XLEN-1];
  assign abs_a = sa ? -dividend : dividend;
  assign abs_b = sb ? -divisor : divisor;
  assign dz    = (divisor == '0);
  assign ovf   = ~op[0] & (dividend == MINV)
               & (&divisor);

  always_comb begin
    spec_val = '0;
    unique case (1'b1)
      dz & ~op[1]:  spec_val = '1;
      dz & op[1]:   spec_val = dividend;
      ovf & ~op[1]: spec_val = MINV;
      default:      spec_val = '0;
    endcase
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .divisor (dvs_q),
    .rem_out (rem_nx),
    .quo_out (quo_nx)
  );

  assign is_rem = (op_q == REM) || (op_q == REMU);
  assign q_fix  = negq_q ? -quo_nx : quo_nx;
  assign r_fix  = negr_q ? -rem_nx[XLEN-1:0]
                         : rem_nx[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= DIV;
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      res_fin <= '0;
      res_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (flush) begin
      state  <= IDLE;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q   <= md_div_op_e'(op);
            negq_q <= sa ^ sb;
            negr_q <= sa;
            cnt    <= '0;
            rem_q  <= '0;
            quo_q  <= abs_a;
            dvs_q  <= abs_b;
            busy_q <= 1'b1;
            if (dz | ovf) begin
              res_fin <= spec_val;
              done_q  <= 1'b1;
              state   <= FIN;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt   <= cnt + CW'(1);
          if (cnt == LAST) begin
            res_fin <= is_rem ? r_fix : q_fix;
            done_q  <= 1'b1;
            state   <= FIN;
          end
        end
        FIN: begin
          res_q  <= res_fin;
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // a flush in the FIN cycle kills done and the new result at once
  assign done   = done_q & ~flush;
  assign busy   = busy_q;
  assign result = done ? res_fin : res_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: random + directed checks of div_unit
// against an arithmetic reference model.
module tb_div_unit;
  import rv32_pkg::*;

  logic        clk = 0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] last_res = 0;

  always #5 clk = ~clk;

  div_unit #(.XLEN(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .flush    (flush),
    .op       (op),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(
    input logic [1:0] o,
    input logic [31:0] a,
    input logic [31:0] b);
    longint sa_l;
    longint sb_l;
    longint r;
    sa_l = longint'($signed(a));
    sb_l = longint'($signed(b));
    if (b == 0) return o[1] ? a : 32'hffff_ffff;
    case (o)
      2'b00:   r = sa_l / sb_l;
      2'b10:   r = sa_l % sb_l;
      2'b01:   return a / b;
      default: return a % b;
    endcase
    return r[31:0];
  endfunction

  function automatic int ref_lat(
    input logic [1:0] o,
    input logic [31:0] a,
    input logic [31:0] b);
    if (b == 0) return 1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hffff_ffff)
      return 1;
    return 33;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // issue one op, then scramble inputs; latency counts the
  // start edge as edge 1
  task automatic check_op(input string tag,
                          input logic [1:0] o,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input bit hold);
    int lat;
    logic [31:0] exp;
    exp = ref_model(o, a, b);
    op = o;
    dividend = a;
    divisor = b;
    start = 1;
    tick();
    lat = 1;
    if (!hold) start = 0;
    op = 2'($urandom);
    dividend = $urandom;
    divisor = $urandom;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    start = 0;
    check({tag, "_lat"}, lat, ref_lat(o, a, b));
    check(tag, result, exp);
    tick();
    check({tag, "_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_hold"}, result, exp);
    last_res = exp;
  endtask

  initial begin
    int dcnt;
    rst_n = 0;
    start = 0;
    flush = 0;
    op = 0;
    dividend = 0;
    divisor = 0;
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_res", result, 0);
    rst_n = 1;
    tick();

    check_op("divu", DIVU, 100, 7, 0);
    check_op("remu", REMU, 100, 7, 0);
    check_op("div_n", DIV, -32'sd7, 2, 0);
    check_op("rem_n", REM, -32'sd7, 2, 0);
    check_op("div_d", DIV, 7, -32'sd2, 0);
    check_op("rem_d", REM, 7, -32'sd2, 0);
    check("div_val", last_res, 32'd1);
    check_op("div_z", DIV, 32'h55, 0, 0);
    check_op("remu_z", REMU, 32'h1234, 0, 0);
    check_op("div_ov", DIV, 32'h8000_0000,
             32'hffff_ffff, 0);
    check_op("rem_ov", REM, 32'h8000_0000,
             32'hffff_ffff, 0);
    check_op("divu_ov", DIVU, 32'h8000_0000,
             32'hffff_ffff, 0);

    // flush mid-CALC
    op = DIVU;
    dividend = 1000;
    divisor = 3;
    start = 1;
    tick();
    start = 0;
    repeat (9) tick();
    flush = 1;
    tick();
    flush = 0;
    check("fl_busy", {31'b0, busy}, 0);
    check("fl_done", {31'b0, done}, 0);
    check("fl_res", result, last_res);
    dcnt = 0;
    repeat (40) begin
      tick();
      if (done) dcnt++;
    end
    check("fl_nodone", dcnt, 0);
    check_op("fl_redo", DIVU, 1000, 3, 0);

    // flush in the FIN cycle
    op = DIVU;
    dividend = 50;
    divisor = 5;
    start = 1;
    tick();
    start = 0;
    dcnt = 1;
    while (!done && dcnt < 40) begin
      tick();
      dcnt++;
    end
    check("ff_seen", {31'b0, done}, 1);
    flush = 1;
    #1;
    check("ff_done", {31'b0, done}, 0);
    check("ff_res", result, last_res);
    tick();
    flush = 0;
    check("ff_busy", {31'b0, busy}, 0);
    check("ff_res2", result, last_res);

    // start and flush together in IDLE
    op = DIV;
    dividend = 9;
    divisor = 3;
    start = 1;
    flush = 1;
    tick();
    start = 0;
    flush = 0;
    check("sf_busy", {31'b0, busy}, 0);
    tick();
    check("sf_done", {31'b0, done}, 0);

    // start held during CALC, then back-to-back
    check_op("hold", DIV, -32'sd100, 7, 1);
    check_op("b2b", REMU, 12345, 100, 0);

    // reset mid-CALC
    op = DIVU;
    dividend = 77;
    divisor = 5;
    start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    rst_n = 0;
    tick();
    check("mr_busy", {31'b0, busy}, 0);
    check("mr_done", {31'b0, done}, 0);
    check("mr_res", result, 0);
    rst_n = 1;
    last_res = 0;
    check_op("mr_redo", DIVU, 77, 5, 0);

    for (int i = 0; i < 400; i++) begin
      logic [1:0]  ro;
      logic [31:0] ra;
      logic [31:0] rb;
      int sel;
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) rb = 0;
      else if (sel == 1) rb = 32'hffff_ffff;
      else if (sel == 2) rb = $urandom_range(1, 15);
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      check_op("rnd", ro, ra, rb, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
